// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the register file port arbiter slice.
//   DW, AW, NREG : register file geometry (16-bit words, 8 registers)
//   state_t      : arbiter FSM states
//   req_t        : one latched requester transaction (op, address, data)
package regfile_pkg;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NREG = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin picker. Holds the id of the last granted requester
// and, when both request, favours the other one.
//   CLK, RESET : clock, asynchronous active-low reset
//   req_i      : request vector, bit n = requester n
//   en_i       : commit the current pick into the last-grant register
//   gnt_o      : id of the requester picked this cycle
//   valid_o    : at least one requester is asking
module rr_arb2 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_o,
  output logic       valid_o
);

  logic last_q;

  always_comb begin
    valid_o = |req_i;
    case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ~last_q;
      default: gnt_o = 1'b0;
    endcase
  end

  // Last grant resets to 1 so requester 0 wins the first contested round.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_q <= 1'b1;
    end else if (en_i && valid_o) begin
      last_q <= gnt_o;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
// Shares the register file write port and A read port between the datapath
// control (requester 0) and the debug/load port (requester 1). Every
// transaction takes three cycles: IDLE samples and grants, ISSUE drives the
// register file, ACK pulses the winner's acknowledge.
//   CLK, RESET            : clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN : requester N transaction request
//   ackN, rdataN          : completion pulse and held read data for requester N
//   rf_aa, rf_da, rf_dd   : register file read address, write address, write data
//   rf_rw                 : registered register file write enable
//   rf_ad                 : register file A read data (combinational from rf_aa)
//   gcnt0, gcnt1          : saturating per-requester grant counters
//   busy                  : FSM is outside IDLE
module regfile_port_arbiter
  import regfile_pkg::state_t, regfile_pkg::req_t,
         regfile_pkg::IDLE, regfile_pkg::ISSUE, regfile_pkg::ACK;
#(
  parameter int DW = 16,
  parameter int AW = 3,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] rf_aa,
  output logic [AW-1:0] rf_da,
  output logic [DW-1:0] rf_dd,
  output logic          rf_rw,
  input  logic [DW-1:0] rf_ad,
  output logic [CW-1:0] gcnt0,
  output logic [CW-1:0] gcnt1,
  output logic          busy
);

  state_t        state_q, state_d;
  req_t          curReq_q, winReq_d;
  logic          gntId_q;
  logic          rfRw_q;
  logic          ack0_q, ack1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic [CW-1:0] gcnt0_q, gcnt1_q;
  logic          gnt;
  logic          gntValid;

  // The arbiter only commits its pick while the FSM is idle, so requests
  // arriving during ISSUE/ACK are ignored until the next IDLE.
  rr_arb2 uArb (
    .CLK     (CLK),
    .RESET   (RESET),
    .req_i   ({req1, req0}),
    .en_i    (state_q == IDLE),
    .gnt_o   (gnt),
    .valid_o (gntValid)
  );

  always_comb begin
    state_d        = state_q;
    winReq_d.we    = gnt ? we1    : we0;
    winReq_d.addr  = gnt ? addr1  : addr0;
    winReq_d.wdata = gnt ? wdata1 : wdata0;
    case (state_q)
      IDLE:    if (gntValid) state_d = ISSUE;
      ISSUE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The register file controls come straight from registers; rf_rw is set
  // at the grant edge so it is high for exactly the ISSUE cycle of a write.
  // Read data is captured at the end of ISSUE, and the ack pulse follows in
  // ACK. Acks and rf_rw default low so they are single-cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      curReq_q <= '0;
      gntId_q  <= 1'b0;
      rfRw_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      gcnt0_q  <= '0;
      gcnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      rfRw_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gntValid) begin
            curReq_q <= winReq_d;
            gntId_q  <= gnt;
            rfRw_q   <= winReq_d.we;
            if (gnt) begin
              if (gcnt1_q != '1) gcnt1_q <= gcnt1_q + CW'(1);
            end else begin
              if (gcnt0_q != '1) gcnt0_q <= gcnt0_q + CW'(1);
            end
          end
        end
        ISSUE: begin
          if (!curReq_q.we) begin
            if (gntId_q) rdata1_q <= rf_ad;
            else         rdata0_q <= rf_ad;
          end
          if (gntId_q) ack1_q <= 1'b1;
          else         ack0_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rf_aa  = curReq_q.addr;
  assign rf_da  = curReq_q.addr;
  assign rf_dd  = curReq_q.wdata;
  assign rf_rw  = rfRw_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign gcnt0  = gcnt0_q;
  assign gcnt1  = gcnt1_q;
  assign busy   = (state_q != IDLE);

endmodule
